wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit.sv | 173 +++++++++++++++++
 tb/tb_wb_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// Write-back unit: retires ALU results directly into the register file and
// parks load instructions until their response word arrives. The response is
// then extracted and extended according to funct3 and the byte offset. Loads
// that never get a response are abandoned after LOAD_TIMEOUT cycles.
// Misaligned accesses, timeouts and unsolicited responses raise sticky error
// flags, which stay set until reset.
module wb_unit #(
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int LOAD_TIMEOUT        = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ex_valid,
    output logic                           ex_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] ex_rd,
    input  logic                           ex_is_load,
    input  logic [2:0]                     ex_funct3,
    input  logic [XLEN-1:0]                ex_result,
    input  logic                           mem_rvalid,
    input  logic [XLEN-1:0]                mem_rdata,
    output logic                           rf_we,
    output logic [REG_FILE_ADDR_WIDTH-1:0] rf_rd,
    output logic [XLEN-1:0]                rf_wd,
    output logic                           load_pending,
    output logic [REG_FILE_ADDR_WIDTH-1:0] pending_rd,
    output logic                           err_misaligned,
    output logic                           err_timeout,
    output logic                           err_spurious,
    output logic [31:0]                    retire_count
);

    localparam int CNT_W = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t                         state_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_cap_q;
    logic [2:0]                     f3_q;
    logic [1:0]                     off_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic                           rf_we_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] rf_rd_q;
    logic [XLEN-1:0]                rf_wd_q;
    logic                           err_mis_q;
    logic                           err_to_q;
    logic                           err_sp_q;
    logic [31:0]                    retire_q;
    logic                           ld_bad;
    logic [XLEN-1:0]                ld_data;

    // True when the captured funct3/offset pair cannot be serviced.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed byte/half of the response word and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] word);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [XLEN-1:0]    res;
        byte_s = signed'(word[8*off +: 8]);
        half_s = signed'(word[16*off[1] +: 16]);
        case (f3)
            F3_LB:   res = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH:   res = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Ready only while idle and out of reset; the handshake completes on ex_valid.
    assign ex_ready     = (state_q == S_IDLE) && rst;
    assign load_pending = (state_q == S_WAIT);
    assign pending_rd   = (state_q == S_WAIT) ? rd_cap_q : '0;

    assign cnt_d   = cnt_q + 1'b1;
    assign ld_bad  = load_misaligned(f3_q, off_q);
    assign ld_data = load_extract(f3_q, off_q, mem_rdata);

    assign rf_we          = rf_we_q;
    assign rf_rd          = rf_rd_q;
    assign rf_wd          = rf_wd_q;
    assign err_misaligned = err_mis_q;
    assign err_timeout    = err_to_q;
    assign err_spurious   = err_sp_q;
    assign retire_count   = retire_q;

    // Retirement FSM: accepts instructions, waits for loads and drives the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rd_cap_q  <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_wd_q   <= '0;
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_sp_q  <= 1'b0;
            retire_q  <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_rvalid) begin
                        err_sp_q <= 1'b1;
                    end
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            rd_cap_q <= ex_rd;
                            f3_q     <= ex_funct3;
                            off_q    <= ex_result[1:0];
                            cnt_q    <= '0;
                            state_q  <= S_WAIT;
                        end else begin
                            rf_we_q  <= (ex_rd != '0);
                            rf_rd_q  <= ex_rd;
                            rf_wd_q  <= ex_result;
                            retire_q <= retire_q + 32'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (ld_bad) begin
                            err_mis_q <= 1'b1;
                        end else begin
                            rf_we_q <= (rd_cap_q != '0);
                            rf_rd_q <= rd_cap_q;
                            rf_wd_q <= ld_data;
                        end
                        retire_q <= retire_q + 32'd1;
                        state_q  <= S_IDLE;
                    end else if (cnt_d == CNT_W'(LOAD_TIMEOUT)) begin
                        err_to_q <= 1'b1;
                        retire_q <= retire_q + 32'd1;
                        cnt_q    <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: transaction-level stimulus (ALU ops, loads with random
// response delays, stray responses, reset mid-load) against a reference model
// of the retirement rules.
module tb_wb_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int T    = 16;

    logic            clk;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [AW-1:0]   ex_rd;
    logic            ex_is_load;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_result;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic            load_pending;
    logic [AW-1:0]   pending_rd;
    logic            err_misaligned;
    logic            err_timeout;
    logic            err_spurious;
    logic [31:0]     retire_count;

    int checks   = 0;
    int failures = 0;

    int unsigned m_retire;
    bit          m_mis;
    bit          m_to;
    bit          m_sp;

    wb_unit #(
        .XLEN(XLEN),
        .REG_FILE_ADDR_WIDTH(AW),
        .LOAD_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_rd(ex_rd),
        .ex_is_load(ex_is_load),
        .ex_funct3(ex_funct3),
        .ex_result(ex_result),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_wd(rf_wd),
        .load_pending(load_pending),
        .pending_rd(pending_rd),
        .err_misaligned(err_misaligned),
        .err_timeout(err_timeout),
        .err_spurious(err_spurious),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ":retire"}, retire_count, m_retire);
        chk({tag, ":mis"}, 32'(err_misaligned), 32'(m_mis));
        chk({tag, ":to"}, 32'(err_timeout), 32'(m_to));
        chk({tag, ":sp"}, 32'(err_spurious), 32'(m_sp));
    endtask

    // Reference load rule: pick the addressed byte/half with shifts and extend arithmetically.
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] off,
                                     input logic [31:0] w, output bit ok, output logic [31:0] v);
        int unsigned b;
        int unsigned h;
        b  = (w >> (8 * off)) & 32'hFF;
        h  = (w >> (16 * (off / 2))) & 32'hFFFF;
        ok = 1'b1;
        v  = 32'h0;
        case (f3)
            3'd0: v = (b >= 128) ? b - 256 : b;
            3'd4: v = b;
            3'd1: begin ok = (off % 2 == 0); v = (h >= 32768) ? h - 65536 : h; end
            3'd5: begin ok = (off % 2 == 0); v = h; end
            3'd2: begin ok = (off == 0); v = w; end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic do_alu(input logic [AW-1:0] rd, input logic [31:0] val);
        @(negedge clk);
        chk("alu_idle_we", 32'(rf_we), 32'd0);
        chk("alu_ready", 32'(ex_ready), 32'd1);
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_rd      = rd;
        ex_result  = val;
        ex_funct3  = 3'($urandom);
        @(negedge clk);
        ex_valid = 1'b0;
        m_retire++;
        chk("alu_we", 32'(rf_we), 32'(rd != 0));
        if (rd != 0) begin
            chk("alu_rd", 32'(rf_rd), 32'(rd));
            chk("alu_wd", rf_wd, val);
        end
        chk_status("alu");
    endtask

    task automatic do_load(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input int delay, input logic [31:0] data);
        logic [31:0] addr;
        logic [31:0] v;
        bit          ok;
        addr       = $urandom;
        addr[1:0]  = off;
        @(negedge clk);
        chk("ld_idle_we", 32'(rf_we), 32'd0);
        chk("ld_ready", 32'(ex_ready), 32'd1);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = rd;
        ex_funct3  = f3;
        ex_result  = addr;
        @(negedge clk);
        // Keep offering an ALU op while waiting; it must not be taken.
        ex_is_load = 1'b0;
        ex_rd      = 5'd7;
        ex_result  = $urandom;
        for (int k = 0; k < T; k++) begin
            chk("wait_ready", 32'(ex_ready), 32'd0);
            chk("wait_pend", 32'(load_pending), 32'd1);
            chk("wait_prd", 32'(pending_rd), 32'(rd));
            chk("wait_we", 32'(rf_we), 32'd0);
            if (k == delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = data;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                ex_valid   = 1'b0;
                ref_load(f3, off, data, ok, v);
                m_retire++;
                if (!ok) m_mis = 1'b1;
                chk("resp_we", 32'(rf_we), 32'(ok && rd != 0));
                if (ok && rd != 0) begin
                    chk("resp_rd", 32'(rf_rd), 32'(rd));
                    chk("resp_wd", rf_wd, v);
                end
                chk("resp_pend", 32'(load_pending), 32'd0);
                chk("resp_prd", 32'(pending_rd), 32'd0);
                chk("resp_ready", 32'(ex_ready), 32'd1);
                chk_status("resp");
                return;
            end
            @(negedge clk);
        end
        ex_valid = 1'b0;
        m_retire++;
        m_to = 1'b1;
        chk("to_we", 32'(rf_we), 32'd0);
        chk("to_pend", 32'(load_pending), 32'd0);
        chk("to_ready", 32'(ex_ready), 32'd1);
        chk_status("to");
    endtask

    task automatic do_spurious();
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        m_sp = 1'b1;
        chk("sp_we", 32'(rf_we), 32'd0);
        chk_status("sp");
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ":ready"}, 32'(ex_ready), 32'd0);
        chk({tag, ":we"}, 32'(rf_we), 32'd0);
        chk({tag, ":rd"}, 32'(rf_rd), 32'd0);
        chk({tag, ":wd"}, rf_wd, 32'd0);
        chk({tag, ":pend"}, 32'(load_pending), 32'd0);
        chk({tag, ":prd"}, 32'(pending_rd), 32'd0);
        chk_status(tag);
    endtask

    task automatic reset_during_wait();
        @(negedge clk);
        ex_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd      = 5'd9;
        ex_funct3  = 3'd2;
        ex_result  = 32'h100;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rw_pend", 32'(load_pending), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_retire = 0; m_mis = 0; m_to = 0; m_sp = 0;
        chk_reset_state("rw_reset");
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        m_sp = 1'b1;
        chk("rw_we", 32'(rf_we), 32'd0);
        chk("rw_ready", 32'(ex_ready), 32'd1);
        chk_status("rw");
    endtask

    initial begin
        int kind;
        logic [2:0] f3;
        rst = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_funct3 = '0; ex_result = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        m_retire = 0; m_mis = 0; m_to = 0; m_sp = 0;
        @(negedge clk);
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        do_alu(5'd5, 32'hDEADBEEF);
        do_alu(5'd0, 32'h1111_2222);
        do_load(5'd3, 3'd0, 2'd3, 2, 32'h80FF_0000);
        do_load(5'd4, 3'd4, 2'd3, 0, 32'h80FF_0000);
        do_load(5'd6, 3'd1, 2'd2, 1, 32'h8001_7FFF);
        do_load(5'd6, 3'd1, 2'd1, 1, 32'h8001_7FFF);
        do_load(5'd8, 3'd2, 2'd0, T - 1, 32'hCAFE_F00D);
        do_load(5'd10, 3'd2, 2'd0, T + 5, 32'h0);
        do_spurious();
        reset_during_wait();

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                do_alu(5'($urandom_range(0, 31)), $urandom);
            end else if (kind < 9) begin
                f3 = 3'($urandom);
                if ($urandom_range(0, 3) != 0) f3[1:0] = 2'($urandom_range(0, 2));
                do_load(5'($urandom_range(0, 31)), f3, 2'($urandom),
                        $urandom_range(0, T + 2), $urandom);
            end else begin
                do_spurious();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
